// File: rtl/bus_pkg.sv
// bus_pkg: shared bus-source count, source index map and arbiter state encoding
package bus_pkg;
  localparam int N_BUS_SRC = 32;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_TURN = 2'd2} state_e;
  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHI    = 5'd18;
  localparam logic [4:0] SRC_ZLO    = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_CSIGN  = 5'd23;
  localparam logic [4:0] SRC_IR     = 5'd24;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner by rotate past ptr, find-first, un-rotate
module rr_pick
  import bus_pkg::*;
(
  input  logic [N_BUS_SRC-1:0] req,
  input  logic [4:0]           ptr,
  output logic [N_BUS_SRC-1:0] winner,
  output logic [4:0]           idx
);
  logic [N_BUS_SRC-1:0] rot;
  logic [4:0] off;
  always_comb begin
    rot = N_BUS_SRC'({req, req} >> ({1'b0, ptr} + 6'd1));
    off = '0;
    for (int i = N_BUS_SRC - 1; i >= 0; i--) if (rot[i]) off = 5'(i);
    idx = off + ptr + 5'd1;
    winner = |req ? N_BUS_SRC'(1) << idx : '0;
  end
endmodule

// File: rtl/bus_out_arbiter.sv
// bus_out_arbiter: round-robin one-hot bus-out grant with hold timeout and turnaround
module bus_out_arbiter
  import bus_pkg::*;
#(
  parameter int N       = N_BUS_SRC,
  parameter int TIMEOUT = 16
)(
  input  logic         clk,
  input  logic         clr_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout_err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  state_e state_q, state_d;
  logic [N-1:0] grant_q, grant_d, win;
  logic [4:0] ptr_q, ptr_d, idx_q, idx_d, win_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q, to_d, hit, held, exit_c;
  rr_pick u_pick (.req(req), .ptr(ptr_q), .winner(win), .idx(win_idx));
  always_comb begin
    hit = (TIMEOUT != 0) && cnt_q == CNT_LAST;
    held = |(req & grant_q);
    exit_c = done || !held || hit;
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
    to_d = 1'b0;
    if (state_q == ST_GRANT) begin
      if (exit_c) begin
        state_d = ST_TURN;
        grant_d = '0;
        ptr_d = idx_q;
        to_d = hit && !done && held;
      end
    end else if (|req) begin
      state_d = ST_GRANT;
      grant_d = win;
      idx_d = win_idx;
      cnt_d = '0;
    end else begin
      state_d = ST_IDLE;
      grant_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q <= 5'(N - 1);
      idx_q <= '0;
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  end
  assign grant = grant_q;
  assign grant_valid = |grant_q;
  assign timeout_err = to_q;
  a_onehot: assert property (@(posedge clk) disable iff (!clr_n) $onehot0(grant_q));
  a_valid: assert property (@(posedge clk) grant_valid == |grant_q);
  a_hold: assert property (@(posedge clk) disable iff (!clr_n)
    (state_q == ST_GRANT && !exit_c) |=> $stable(grant_q));
endmodule

// File: tb/tb_bus_out_arbiter.sv
// tb_bus_out_arbiter: directed checks of grant order, turnaround, timeout and reset
module tb_bus_out_arbiter;
  logic clk, clr_n, done, grant_valid, timeout_err;
  logic [31:0] req, grant, r, prev_g;
  int checks, errors, max_wait;
  int wait_c[32];
  bus_out_arbiter #(.N(32), .TIMEOUT(16)) dut (
    .clk(clk), .clr_n(clr_n), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .timeout_err(timeout_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    max_wait = 0;
    clr_n = 1'b0;
    req = '0;
    done = 1'b0;
    step;
    step;
    chk("rst_grant", grant, 32'h0);
    chk("rst_valid", {31'd0, grant_valid}, 32'd0);
    chk("rst_to", {31'd0, timeout_err}, 32'd0);
    clr_n = 1'b1;
    req = 32'h0000_0004;
    step;
    chk("first_grant", grant, 32'h0000_0004);
    chk("first_valid", {31'd0, grant_valid}, 32'd1);
    done = 1'b1;
    step;
    chk("done_turn", grant, 32'h0);
    chk("turn_valid", {31'd0, grant_valid}, 32'd0);
    done = 1'b0;
    req = '0;
    step;
    chk("idle", grant, 32'h0);
    clr_n = 1'b0;
    step;
    clr_n = 1'b1;
    req = 32'h8000_0001;
    done = 1'b1;
    step;
    chk("rr0", grant, 32'h0000_0001);
    step;
    chk("rr1", grant, 32'h0);
    step;
    chk("rr2", grant, 32'h8000_0000);
    step;
    chk("rr3", grant, 32'h0);
    step;
    chk("rr4", grant, 32'h0000_0001);
    req = '0;
    done = 1'b0;
    step;
    step;
    req = 32'h0000_0100;
    step;
    chk("to_grant", grant, 32'h0000_0100);
    for (int i = 1; i < 16; i++) begin
      step;
      chk("to_hold", grant, 32'h0000_0100);
      chk("to_quiet", {31'd0, timeout_err}, 32'd0);
    end
    step;
    chk("to_release", grant, 32'h0);
    chk("to_pulse", {31'd0, timeout_err}, 32'd1);
    step;
    chk("to_regrant", grant, 32'h0000_0100);
    chk("to_pulse_end", {31'd0, timeout_err}, 32'd0);
    for (int i = 1; i < 16; i++) step;
    chk("edge_hold", grant, 32'h0000_0100);
    done = 1'b1;
    step;
    chk("edge_release", grant, 32'h0);
    chk("edge_no_to", {31'd0, timeout_err}, 32'd0);
    done = 1'b0;
    req = '0;
    step;
    req = 32'h0000_0020;
    step;
    step;
    step;
    chk("wd_hold", grant, 32'h0000_0020);
    req = '0;
    step;
    chk("wd_release", grant, 32'h0);
    chk("wd_no_to", {31'd0, timeout_err}, 32'd0);
    step;
    req = 32'h0001_0000;
    step;
    chk("pre_rst", grant, 32'h0001_0000);
    step;
    clr_n = 1'b0;
    step;
    chk("mid_rst_grant", grant, 32'h0);
    chk("mid_rst_valid", {31'd0, grant_valid}, 32'd0);
    chk("mid_rst_to", {31'd0, timeout_err}, 32'd0);
    clr_n = 1'b1;
    req = 32'h0001_0001;
    step;
    chk("post_rst", grant, 32'h0000_0001);
    done = 1'b1;
    step;
    chk("post_turn", grant, 32'h0);
    step;
    chk("rerequest_last", grant, 32'h0001_0000);
    done = 1'b0;
    req = '0;
    step;
    step;
    prev_g = grant;
    for (int c = 0; c < 10000; c++) begin
      r = req ^ (($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'd0);
      req = r;
      done = ($urandom_range(0, 3) == 0);
      step;
      chk("onehot", 32'($onehot0(grant)), 32'd1);
      chk("valid", {31'd0, grant_valid}, {31'd0, |grant});
      for (int i = 0; i < 32; i++) begin
        if (!r[i]) wait_c[i] = 0;
        else if (grant != 0 && prev_g == 0) begin
          if (grant[i]) wait_c[i] = 0;
          else wait_c[i]++;
          if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end
      end
      prev_g = grant;
    end
    chk("starve", 32'(max_wait <= 31), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
